instr_fetch_unit: RTL and testbench

- Upstream stage of the multi-cycle control path. Owns the program counter (PC) and the instruction register (IR).
- Fetches instruction words from instruction memory over a req/ack handshake and presents `Opcode` to the control FSM.
- Applies PC updates requested by the control path: sequential/jump via the ALU result, conditional branch via its own target adder.
- Sits between the control path, the datapath ALU and the instruction memory port.

---
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request port: req/addr out, rdata/ack back.
// master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) ();
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (
      output req, addr,
      input  rdata, ack
   );

   modport slave (
      input  req, addr,
      output rdata, ack
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over req/ack.
// Ports: clk/rst, control strobes, alu_result/zero_flag, imem port,
// PC/Instr/Opcode, fetch_busy/fetch_err status.
module instr_fetch_unit #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int RESET_PC = 0,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Instr_ren,
   input  logic              PC_write,
   input  logic              PC_select,
   input  logic              BPC_write,
   input  logic              NBPC_write,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              zero_flag,
   instr_fetch_unit_if.master imem,
   output logic [ADDR_W-1:0] PC,
   output logic [DATA_W-1:0] Instr,
   output logic [3:0]        Opcode,
   output logic              fetch_busy,
   output logic              fetch_err
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state, state_n;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] next_pc;
   logic              load;
   logic              start;
   logic              ld_instr;
   logic              set_err;
   logic              cnt_inc;
   logic              bypass;

   // Branch offset is the sign-extended low byte of the IR
   assign br_off  = {{(ADDR_W-8){Instr[7]}}, Instr[7:0]};
   assign next_pc = PC_select ? (PC + br_off)
                              : alu_result[ADDR_W-1:0];
   assign load    = PC_write
                  | (BPC_write & zero_flag)
                  | (NBPC_write & ~zero_flag);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      imem.req   = 1'b0;
      fetch_busy = 1'b0;
      start      = 1'b0;
      ld_instr   = 1'b0;
      set_err    = 1'b0;
      cnt_inc    = 1'b0;
      bypass     = 1'b0;
      unique case (state)
         IDLE: begin
            if (Instr_ren) begin
               start   = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            imem.req   = 1'b1;
            fetch_busy = 1'b1;
            // A second request while busy is an overrun
            if (Instr_ren) set_err = 1'b1;
            // Ack beats timeout when both land together
            if (imem.ack) begin
               ld_instr = 1'b1;
               bypass   = 1'b1;
               state_n  = IDLE;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               set_err = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         PC         <= ADDR_W'(RESET_PC);
         Instr      <= '0;
         cnt        <= '0;
         fetch_addr <= '0;
         fetch_err  <= 1'b0;
      end else begin
         if (load)     PC         <= next_pc;
         if (start)    fetch_addr <= PC;
         if (start)    cnt        <= '0;
         if (cnt_inc)  cnt        <= cnt + 8'd1;
         if (ld_instr) Instr      <= imem.rdata;
         if (set_err)  fetch_err  <= 1'b1;
      end
   end

   assign imem.addr = fetch_addr;

   // Let the control FSM decode the word on the ack cycle itself
   assign Opcode = bypass ? imem.rdata[DATA_W-1 -: 4]
                          : Instr[DATA_W-1 -: 4];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// Drives the imem slave side by hand and checks hand-computed values.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        Instr_ren, PC_write, PC_select;
   logic        BPC_write, NBPC_write;
   logic [15:0] alu_result;
   logic        zero_flag;
   logic [15:0] PC, Instr;
   logic [3:0]  Opcode;
   logic        fetch_busy, fetch_err;

   int ncmp = 0;
   int nerr = 0;

   instr_fetch_unit_if #(.DATA_W(16), .ADDR_W(16)) imem ();

   instr_fetch_unit #(
      .DATA_W(16), .ADDR_W(16), .RESET_PC(0), .TIMEOUT(15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Instr_ren  (Instr_ren),
      .PC_write   (PC_write),
      .PC_select  (PC_select),
      .BPC_write  (BPC_write),
      .NBPC_write (NBPC_write),
      .alu_result (alu_result),
      .zero_flag  (zero_flag),
      .imem       (imem.master),
      .PC         (PC),
      .Instr      (Instr),
      .Opcode     (Opcode),
      .fetch_busy (fetch_busy),
      .fetch_err  (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      Instr_ren  = 1'b0;
      PC_write   = 1'b0;
      PC_select  = 1'b0;
      BPC_write  = 1'b0;
      NBPC_write = 1'b0;
      imem.ack   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      alu_result = '0;
      zero_flag  = 1'b0;
      imem.rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_pc",    PC, 0);
      chk("rst_instr", Instr, 0);
      chk("rst_req",   imem.req, 0);
      chk("rst_busy",  fetch_busy, 0);
      chk("rst_err",   fetch_err, 0);
      chk("rst_op",    Opcode, 0);

      // 1: fetch with PC+1 load on the same cycle
      Instr_ren = 1'b1; PC_write = 1'b1; alu_result = 16'h0001;
      tick();
      idle_in();
      #1;
      chk("t1_req",  imem.req, 1);
      chk("t1_addr", imem.addr, 16'h0000);
      chk("t1_busy", fetch_busy, 1);
      chk("t1_pc",   PC, 16'h0001);
      tick();
      tick();
      imem.ack = 1'b1; imem.rdata = 16'h8123;
      #1;
      chk("t1_bypass", Opcode, 4'b1000);
      tick();
      idle_in();
      #1;
      chk("t1_instr", Instr, 16'h8123);
      chk("t1_busy2", fetch_busy, 0);
      chk("t1_req2",  imem.req, 0);
      chk("t1_op",    Opcode, 4'h8);
      chk("t1_hold",  imem.addr, 16'h0000);
      chk("t1_err",   fetch_err, 0);

      // 2: conditional branches, offset 0xFC = -4
      PC_write = 1'b1; alu_result = 16'h0010;
      tick();
      idle_in();
      Instr_ren = 1'b1;
      tick();
      idle_in();
      imem.ack = 1'b1; imem.rdata = 16'h80FC;
      tick();
      idle_in();
      #1;
      chk("t2_instr", Instr, 16'h80FC);
      BPC_write = 1'b1; PC_select = 1'b1; zero_flag = 1'b1;
      tick();
      idle_in();
      #1;
      chk("t2_bz1", PC, 16'h000C);
      PC_write = 1'b1; alu_result = 16'h0010;
      tick();
      idle_in();
      BPC_write = 1'b1; PC_select = 1'b1; zero_flag = 1'b0;
      tick();
      idle_in();
      #1;
      chk("t2_bz0", PC, 16'h0010);
      NBPC_write = 1'b1; PC_select = 1'b1; zero_flag = 1'b0;
      tick();
      idle_in();
      #1;
      chk("t2_nbz", PC, 16'h000C);

      // 3: branch target wraps past 0xFFFF
      PC_write = 1'b1; alu_result = 16'hFFFF;
      tick();
      idle_in();
      Instr_ren = 1'b1;
      tick();
      idle_in();
      #1;
      chk("t3_addr", imem.addr, 16'hFFFF);
      imem.ack = 1'b1; imem.rdata = 16'h3002;
      tick();
      idle_in();
      PC_write = 1'b1; PC_select = 1'b1;
      tick();
      idle_in();
      #1;
      chk("t3_wrap", PC, 16'h0001);

      // 4a: no ack -> timeout after 15 wait cycles
      Instr_ren = 1'b1;
      tick();
      idle_in();
      for (int i = 0; i < 14; i++) tick();
      chk("t4_req14", imem.req, 1);
      tick();
      chk("t4_req15",  imem.req, 0);
      chk("t4_err",    fetch_err, 1);
      chk("t4_instr",  Instr, 16'h3002);
      chk("t4_busy",   fetch_busy, 0);

      // 4b: ack on the last allowed cycle wins
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t4_errclr", fetch_err, 0);
      Instr_ren = 1'b1;
      tick();
      idle_in();
      for (int i = 0; i < 14; i++) tick();
      imem.ack = 1'b1; imem.rdata = 16'hA555;
      tick();
      idle_in();
      #1;
      chk("t4_late",   Instr, 16'hA555);
      chk("t4_noerr",  fetch_err, 0);
      chk("t4_lreq",   imem.req, 0);

      // 5: overrun request during WAIT
      PC_write = 1'b1; alu_result = 16'h0040;
      tick();
      idle_in();
      Instr_ren = 1'b1;
      tick();
      idle_in();
      Instr_ren = 1'b1; PC_write = 1'b1; alu_result = 16'h0050;
      tick();
      idle_in();
      #1;
      chk("t5_addr", imem.addr, 16'h0040);
      chk("t5_err",  fetch_err, 1);
      chk("t5_req",  imem.req, 1);
      imem.ack = 1'b1; imem.rdata = 16'h7777;
      tick();
      idle_in();
      #1;
      chk("t5_instr", Instr, 16'h7777);
      chk("t5_req2",  imem.req, 0);

      // 6: reset mid-WAIT, then a stale ack
      rst = 1'b1;
      tick();
      rst = 1'b0;
      Instr_ren = 1'b1;
      tick();
      idle_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_req",   imem.req, 0);
      chk("t6_instr", Instr, 0);
      chk("t6_pc",    PC, 0);
      chk("t6_busy",  fetch_busy, 0);
      imem.ack = 1'b1; imem.rdata = 16'hBEEF;
      #1;
      chk("t6_op_ack", Opcode, 0);
      tick();
      idle_in();
      #1;
      chk("t6_stale", Instr, 0);
      chk("t6_req2",  imem.req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule
